mem_wb_stage: RTL and testbench

- Memory stage and MEM/WB pipeline register of the 5-stage MIPS core.
- Sits directly downstream of the EX/MEM latch and consumes its M-stage outputs.
- Contains the word-addressed data memory and models a configurable access latency, raising stallM to the hazard unit while an access is in flight.
- Registers the W-stage control, data and result for register-file writeback.

---
 rtl/mem_wb_stage_if.sv | 45 ++++
 rtl/mem_wb_stage.sv | 156 +++++++++++++++
 tb/tb_mem_wb_stage.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/mem_wb_stage_if.sv
// ----------------------------------------------------------------------------
// mem_wb_stage_if
// Bundles the M-stage inputs and the W-stage outputs of mem_wb_stage.
//   master : the EX/MEM side and the writeback/hazard consumers (testbench)
//   slave  : mem_wb_stage itself
// Signals:
//   regwriteM, memtoRegM, memWriteM, aluOutM, writeDataM, writeRegM  (M stage)
//   stallM                                                           (to hazard unit)
//   regwriteW, memtoRegW, readDataW, aluOutW, writeRegW, resultW     (W stage)
//   misalignM  only when MEM_ALIGN_CHECK_EN is defined
// ----------------------------------------------------------------------------
interface mem_wb_stage_if;
    logic        regwriteM;
    logic        memtoRegM;
    logic        memWriteM;
    logic [31:0] aluOutM;
    logic [31:0] writeDataM;
    logic [4:0]  writeRegM;
    logic        stallM;
    logic        regwriteW;
    logic        memtoRegW;
    logic [31:0] readDataW;
    logic [31:0] aluOutW;
    logic [4:0]  writeRegW;
    logic [31:0] resultW;
`ifdef MEM_ALIGN_CHECK_EN
    logic        misalignM;
`endif

    modport master (
`ifdef MEM_ALIGN_CHECK_EN
        input  misalignM,
`endif
        output regwriteM, memtoRegM, memWriteM, aluOutM, writeDataM, writeRegM,
        input  stallM, regwriteW, memtoRegW, readDataW, aluOutW, writeRegW, resultW
    );

    modport slave (
`ifdef MEM_ALIGN_CHECK_EN
        output misalignM,
`endif
        input  regwriteM, memtoRegM, memWriteM, aluOutM, writeDataM, writeRegM,
        output stallM, regwriteW, memtoRegW, readDataW, aluOutW, writeRegW, resultW
    );
endinterface

// File: rtl/mem_wb_stage.sv
// ----------------------------------------------------------------------------
// mem_wb_stage
// Memory stage plus MEM/WB pipeline register of the 5-stage MIPS core.
// Holds the word-addressed data memory, models a fixed access latency of
// MEM_LAT extra cycles per load/store (stallM high while in flight) and
// registers the writeback control/data.
// Ports:
//   clk    rising-edge clock
//   clr_n  asynchronous active-low reset
//   bus    mem_wb_stage_if.slave (M inputs, stallM, W outputs)
// Parameters:
//   DEPTH    data memory words (power of two, >= 4)
//   MEM_LAT  extra cycles per memory access, 0..7
// Optional feature: define MEM_ALIGN_CHECK_EN to flag misaligned accesses on
// misalignM; such accesses complete at once, suppress the store and bubble W.
//
// state | meaning
// IDLE  | no access in flight; non-memory ops and MEM_LAT=0 ops complete here
// BUSY  | access in flight; cnt counts down to the completion cycle
// ----------------------------------------------------------------------------
module mem_wb_stage #(
    parameter int DEPTH   = 64,
    parameter int MEM_LAT = 2
) (
    input  logic          clk,
    input  logic          clr_n,
    mem_wb_stage_if.slave bus
);
    localparam int         IDX  = $clog2(DEPTH);
    localparam logic [2:0] LAT3 = 3'(MEM_LAT);

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    state_t          state_q, state_d;
    logic [2:0]      cnt_q, cnt_d;
    logic            acc, misalign, stall, done, mem_we;
    logic [IDX-1:0]  idx;
    logic [31:0]     rdata;
    logic [31:0]     mem_q [DEPTH];

    logic            regwrite_w_q, regwrite_w_d;
    logic            memtoreg_w_q, memtoreg_w_d;
    logic [31:0]     readdata_w_q, readdata_w_d;
    logic [31:0]     aluout_w_q, aluout_w_d;
    logic [4:0]      writereg_w_q, writereg_w_d;

    assign acc = bus.memtoRegM | bus.memWriteM;
    // Upper address bits beyond the index are dropped, so addresses wrap.
    assign idx = bus.aluOutM[IDX+1:2];

`ifdef MEM_ALIGN_CHECK_EN
    assign misalign      = acc & (bus.aluOutM[1:0] != 2'b00);
    assign bus.misalignM = misalign;
`else
    assign misalign = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q <= IDLE;
            cnt_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: if (acc && (LAT3 != 3'd0) && !misalign) begin
                state_d = BUSY;
                cnt_d   = LAT3 - 3'd1;
            end
            BUSY: if (cnt_q != 3'd0) cnt_d = cnt_q - 3'd1;
                  else               state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs. Gating with clr_n keeps stallM low and blocks any memory
    // write while reset is held, even if upstream is still presenting an op.
    always_comb begin
        stall = 1'b0;
        done  = 1'b0;
        if (clr_n) begin
            unique case (state_q)
                IDLE: begin
                    stall = acc & (LAT3 != 3'd0) & ~misalign;
                    done  = ~stall;
                end
                BUSY: begin
                    stall = (cnt_q != 3'd0);
                    done  = (cnt_q == 3'd0);
                end
                default: ;
            endcase
        end
    end

    assign bus.stallM = stall;
    assign mem_we     = done & bus.memWriteM & ~misalign;
    // Asynchronous read, sampled at the same edge as a write: an illegal
    // load+store therefore returns the pre-write word.
    assign rdata      = mem_q[idx];

    always_ff @(posedge clk) begin
        if (mem_we) mem_q[idx] <= bus.writeDataM;
    end

    // W register next values: load on a clean completion, bubble on stall or
    // on a misaligned completion, otherwise hold.
    always_comb begin
        regwrite_w_d = regwrite_w_q;
        memtoreg_w_d = memtoreg_w_q;
        readdata_w_d = readdata_w_q;
        aluout_w_d   = aluout_w_q;
        writereg_w_d = writereg_w_q;
        if (done && !misalign) begin
            regwrite_w_d = bus.regwriteM;
            memtoreg_w_d = bus.memtoRegM;
            readdata_w_d = rdata;
            aluout_w_d   = bus.aluOutM;
            writereg_w_d = bus.writeRegM;
        end else if (stall || done) begin
            regwrite_w_d = 1'b0;
            memtoreg_w_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            regwrite_w_q <= 1'b0;
            memtoreg_w_q <= 1'b0;
            readdata_w_q <= 32'd0;
            aluout_w_q   <= 32'd0;
            writereg_w_q <= 5'd0;
        end else begin
            regwrite_w_q <= regwrite_w_d;
            memtoreg_w_q <= memtoreg_w_d;
            readdata_w_q <= readdata_w_d;
            aluout_w_q   <= aluout_w_d;
            writereg_w_q <= writereg_w_d;
        end
    end

    assign bus.regwriteW = regwrite_w_q;
    assign bus.memtoRegW = memtoreg_w_q;
    assign bus.readDataW = readdata_w_q;
    assign bus.aluOutW   = aluout_w_q;
    assign bus.writeRegW = writereg_w_q;
    assign bus.resultW   = memtoreg_w_q ? readdata_w_q : aluout_w_q;
endmodule

// File: tb/tb_mem_wb_stage.sv
module tb_mem_wb_stage;
    logic clk;
    logic clr_n;
    int   checks = 0;
    int   errors = 0;

    mem_wb_stage_if if0 ();
    mem_wb_stage_if if2 ();
    mem_wb_stage_if if3 ();

    mem_wb_stage #(.DEPTH(64), .MEM_LAT(0)) u_lat0 (.clk(clk), .clr_n(clr_n), .bus(if0));
    mem_wb_stage #(.DEPTH(64), .MEM_LAT(2)) u_lat2 (.clk(clk), .clr_n(clr_n), .bus(if2));
    mem_wb_stage #(.DEPTH(64), .MEM_LAT(3)) u_lat3 (.clk(clk), .clr_n(clr_n), .bus(if3));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        mtr;
        logic        mw;
        logic        rw;
        logic [31:0] alu;
        logic [31:0] wd;
        logic [4:0]  wr;
        logic        exp_rw;
        logic [31:0] exp_res;
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic set0(input logic mtr, input logic mw, input logic rw,
                        input logic [31:0] alu, input logic [31:0] wd, input logic [4:0] wr);
        if0.memtoRegM = mtr; if0.memWriteM = mw; if0.regwriteM = rw;
        if0.aluOutM = alu; if0.writeDataM = wd; if0.writeRegM = wr;
    endtask

    task automatic set2(input logic mtr, input logic mw, input logic rw,
                        input logic [31:0] alu, input logic [31:0] wd, input logic [4:0] wr);
        if2.memtoRegM = mtr; if2.memWriteM = mw; if2.regwriteM = rw;
        if2.aluOutM = alu; if2.writeDataM = wd; if2.writeRegM = wr;
    endtask

    task automatic set3(input logic mtr, input logic mw, input logic rw,
                        input logic [31:0] alu, input logic [31:0] wd, input logic [4:0] wr);
        if3.memtoRegM = mtr; if3.memWriteM = mw; if3.regwriteM = rw;
        if3.aluOutM = alu; if3.writeDataM = wd; if3.writeRegM = wr;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Counts stalled cycles on the LAT=2 instance, checking the W bubble
    // after each stalled edge; leaves time just after the last stalled edge.
    task automatic run_stall2(input string nm, output int n);
        n = 0;
        for (int c = 0; c < 12 && if2.stallM; c++) begin
            n++;
            tick();
            chk({nm, "_bubble_rw"}, 32'(if2.regwriteW), 32'd0);
        end
    endtask

    task automatic run_stall3(output int n);
        n = 0;
        for (int c = 0; c < 12 && if3.stallM; c++) begin
            n++;
            tick();
        end
    endtask

    int n;

    initial begin
        vecs[0] = '{1'b0, 1'b1, 1'b0, 32'h04,  32'h11111111, 5'd0, 1'b0, 32'h04};
        vecs[1] = '{1'b1, 1'b0, 1'b1, 32'h04,  32'h0,        5'd3, 1'b1, 32'h11111111};
        vecs[2] = '{1'b0, 1'b1, 1'b0, 32'h08,  32'h22222222, 5'd0, 1'b0, 32'h08};
        vecs[3] = '{1'b1, 1'b0, 1'b1, 32'h08,  32'h0,        5'd4, 1'b1, 32'h22222222};
        vecs[4] = '{1'b0, 1'b1, 1'b0, 32'h100, 32'hA5A5A5A5, 5'd0, 1'b0, 32'h100};
        vecs[5] = '{1'b1, 1'b0, 1'b1, 32'h0,   32'h0,        5'd6, 1'b1, 32'hA5A5A5A5};
        vecs[6] = '{1'b0, 1'b0, 1'b1, 32'hCAFE,32'h0,        5'd9, 1'b1, 32'hCAFE};
        vecs[7] = '{1'b1, 1'b0, 1'b1, 32'h04,  32'h0,        5'd10,1'b1, 32'h11111111};
        vecs[8] = '{1'b1, 1'b1, 1'b1, 32'h04,  32'h33333333, 5'd11,1'b1, 32'h11111111};
        vecs[9] = '{1'b1, 1'b0, 1'b1, 32'h04,  32'h0,        5'd12,1'b1, 32'h33333333};

        set0(0, 0, 0, 0, 0, 0);
        set2(0, 0, 0, 0, 0, 0);
        set3(0, 0, 0, 0, 0, 0);
        clr_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 clr_n = 1'b1;
        tick();

        // Make the W registers non-zero, then reset mid-cycle with all inputs 1.
        set2(0, 0, 1, 32'h0000FFFF, 0, 5'd31);
        tick();
        chk("pre_reset_rw", 32'(if2.regwriteW), 32'd1);
        chk("pre_reset_res", if2.resultW, 32'h0000FFFF);
        set2(1, 1, 1, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd31);
        #2 clr_n = 1'b0;
        #1;
        chk("rst_regwriteW", 32'(if2.regwriteW), 32'd0);
        chk("rst_memtoRegW", 32'(if2.memtoRegW), 32'd0);
        chk("rst_readDataW", if2.readDataW, 32'd0);
        chk("rst_aluOutW", if2.aluOutW, 32'd0);
        chk("rst_writeRegW", 32'(if2.writeRegW), 32'd0);
        chk("rst_resultW", if2.resultW, 32'd0);
        chk("rst_stallM", 32'(if2.stallM), 32'd0);
        tick();
        chk("rst_held_stallM", 32'(if2.stallM), 32'd0);
        set2(0, 0, 1, 32'h1234, 0, 5'd5);
        #1 clr_n = 1'b1;
        #1 chk("post_rst_stallM", 32'(if2.stallM), 32'd0);
        tick();
        chk("nop_regwriteW", 32'(if2.regwriteW), 32'd1);
        chk("nop_resultW", if2.resultW, 32'h1234);
        chk("nop_writeRegW", 32'(if2.writeRegW), 32'd5);

        // LAT=2 store then load
        set2(0, 1, 0, 32'h10, 32'hDEADBEEF, 5'd0);
        #1 run_stall2("st2", n);
        chk("st2_stall_cycles", 32'(n), 32'd2);
        chk("st2_done_stallM", 32'(if2.stallM), 32'd0);
        tick();
        set2(1, 0, 1, 32'h10, 0, 5'd8);
        #1 chk("ld2_first_stallM", 32'(if2.stallM), 32'd1);
        run_stall2("ld2", n);
        chk("ld2_stall_cycles", 32'(n), 32'd2);
        tick();
        chk("ld2_readDataW", if2.readDataW, 32'hDEADBEEF);
        chk("ld2_resultW", if2.resultW, 32'hDEADBEEF);
        chk("ld2_memtoRegW", 32'(if2.memtoRegW), 32'd1);
        chk("ld2_regwriteW", 32'(if2.regwriteW), 32'd1);
        chk("ld2_writeRegW", 32'(if2.writeRegW), 32'd8);
        set2(0, 0, 0, 0, 0, 0);

        // LAT=0 table: alternating stores/loads, wrap-around, illegal load+store
        for (int i = 0; i < 10; i++) begin
            set0(vecs[i].mtr, vecs[i].mw, vecs[i].rw, vecs[i].alu, vecs[i].wd, vecs[i].wr);
            #1 chk($sformatf("v%0d_stallM", i), 32'(if0.stallM), 32'd0);
            tick();
            chk($sformatf("v%0d_regwriteW", i), 32'(if0.regwriteW), 32'(vecs[i].exp_rw));
            chk($sformatf("v%0d_resultW", i), if0.resultW, vecs[i].exp_res);
            chk($sformatf("v%0d_writeRegW", i), 32'(if0.writeRegW), 32'(vecs[i].wr));
        end
        set0(0, 0, 0, 0, 0, 0);

        // LAT=3: initialise word 0x20 to 0x77, then abort a store with reset
        set3(0, 1, 0, 32'h20, 32'h77, 5'd0);
        #1 run_stall3(n);
        chk("init3_stall_cycles", 32'(n), 32'd3);
        tick();
        set3(0, 1, 0, 32'h20, 32'h1, 5'd0);
        #1 chk("ab_stall1", 32'(if3.stallM), 32'd1);
        tick();
        chk("ab_stall2", 32'(if3.stallM), 32'd1);
        clr_n = 1'b0;
        #1 chk("ab_rst_stallM", 32'(if3.stallM), 32'd0);
        set3(0, 0, 0, 0, 0, 0);
        #1 clr_n = 1'b1;
        #1 chk("ab_rel_stallM", 32'(if3.stallM), 32'd0);
        tick();
        chk("ab_idle_stallM", 32'(if3.stallM), 32'd0);
        set3(1, 0, 1, 32'h20, 0, 5'd2);
        #1 run_stall3(n);
        chk("ld3_stall_cycles", 32'(n), 32'd3);
        tick();
        chk("ld3_readDataW", if3.readDataW, 32'h77);
        chk("ld3_resultW", if3.resultW, 32'h77);
        set3(0, 0, 0, 0, 0, 0);

`ifdef MEM_ALIGN_CHECK_EN
        tick();
        set2(0, 0, 1, 32'h55, 0, 5'd1);
        tick();
        set2(0, 1, 1, 32'h13, 32'h12345678, 5'd7);
        #1 chk("mis_misalignM", 32'(if2.misalignM), 32'd1);
        chk("mis_stallM", 32'(if2.stallM), 32'd0);
        tick();
        chk("mis_regwriteW", 32'(if2.regwriteW), 32'd0);
        set2(1, 0, 1, 32'h10, 0, 5'd8);
        #1 chk("mis_ld_misalignM", 32'(if2.misalignM), 32'd0);
        run_stall2("misld", n);
        chk("misld_stall_cycles", 32'(n), 32'd2);
        tick();
        chk("misld_readDataW", if2.readDataW, 32'hDEADBEEF);
        set2(0, 0, 0, 0, 0, 0);
`endif

        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
